// File: rtl/bcd_seq_shifter.sv
// Sequential bidirectional packed-BCD digit shifter: one digit per clock, start/done handshake.
// Reports the last digit shifted out, loss of nonzero digits and non-BCD operand digits.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for i_start; results from the last operation held
//   SHIFT | shifting one digit per clock until the counter reaches 0
//   DONE  | o_done pulse; results valid; a new start is accepted here
module bcd_seq_shifter #(
   parameter int NUM_DIGITS = 8,
   parameter int AMT_WIDTH  = $clog2(NUM_DIGITS + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic                    i_dir,
   input  logic [AMT_WIDTH-1:0]    i_amt,
   input  logic [NUM_DIGITS*4-1:0] i_num,
   input  logic [3:0]              i_fill,
   output logic                    o_ready,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [NUM_DIGITS*4-1:0] o_num,
   output logic [3:0]              o_digit,
   output logic                    o_lost,
   output logic                    o_err
);

   localparam int                   W       = NUM_DIGITS * 4;
   localparam logic [AMT_WIDTH-1:0] MAX_AMT = AMT_WIDTH'(NUM_DIGITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [W-1:0]           r_num;
   logic                   r_dir;
   logic [3:0]             r_fill;
   logic [AMT_WIDTH-1:0]   r_cnt;
   logic [3:0]             r_digit;
   logic                   r_lost;
   logic                   r_err;

   logic                   w_accept;
   logic                   w_step;
   logic [AMT_WIDTH-1:0]   w_amt_clamped;
   logic                   w_bad_digit;
   logic [3:0]             w_out_digit;

   assign w_accept      = i_start && (r_state != SHIFT);
   assign w_step        = (r_state == SHIFT);
   assign w_amt_clamped = (i_amt > MAX_AMT) ? MAX_AMT : i_amt;
   assign w_out_digit   = r_dir ? r_num[3:0] : r_num[W-1 -: 4];

   always_comb begin
      w_bad_digit = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i_num[i*4 +: 4] > 4'd9) w_bad_digit = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (i_start) w_state_nxt = (w_amt_clamped != '0) ? SHIFT : DONE;
            else         w_state_nxt = IDLE;
         end
         SHIFT: begin
            if (r_cnt == AMT_WIDTH'(1)) w_state_nxt = DONE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_num   <= '0;
         r_dir   <= 1'b0;
         r_fill  <= '0;
         r_cnt   <= '0;
         r_digit <= '0;
         r_lost  <= 1'b0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_num   <= i_num;
         r_dir   <= i_dir;
         r_fill  <= i_fill;
         r_cnt   <= w_amt_clamped;
         r_digit <= '0;
         r_lost  <= 1'b0;
         r_err   <= w_bad_digit;
      end else if (w_step) begin
         r_num   <= r_dir ? {r_fill, r_num[W-1:4]} : {r_num[W-5:0], r_fill};
         r_digit <= w_out_digit;
         r_lost  <= r_lost | (w_out_digit != 4'd0);
         r_cnt   <= r_cnt - AMT_WIDTH'(1);
      end
   end

   assign o_ready = (r_state != SHIFT);
   assign o_busy  = (r_state == SHIFT);
   assign o_done  = (r_state == DONE);
   assign o_num   = r_num;
   assign o_digit = r_digit;
   assign o_lost  = r_lost;
   assign o_err   = r_err;

endmodule
